// File: rtl/flash_pkg.sv
// ---------------------------------------------------------------------------
// flash_pkg
// Shared definitions for the SPI flash read engine: the READ opcode, the
// flash address width, the command/address frame width and the FSM state
// type. The optional power-up wait state (ST_INIT_WAIT) is only entered
// when FLASH_STARTUP_WAIT_EN is defined.
// ---------------------------------------------------------------------------
package flash_pkg;

    localparam logic [7:0] CMD_READ     = 8'h03;
    localparam int         FLASH_ADDR_W = 24;
    localparam int         FRAME_W      = 8 + FLASH_ADDR_W;  // opcode + address

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_IDLE,
        ST_SEND,
        ST_READ,
        ST_DONE
    } state_e;

    // The SPI bus is owned (CS low, SCLK toggling) only while shifting.
    function automatic logic drives_bus(input state_e s);
        return (s == ST_SEND) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/flash_byte_buffer.sv
// ---------------------------------------------------------------------------
// flash_byte_buffer
// BYTE_COUNT x 8 register array holding the bytes of the last read.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset, clears every byte
//   wr_en_i   write strobe from the read engine
//   wr_idx_i  byte slot to write
//   wr_data_i byte to write
//   rd_idx_i  byte slot to read
//   rd_data_o registered read data, one cycle after rd_idx_i
// ---------------------------------------------------------------------------
module flash_byte_buffer #(
    parameter int BYTE_COUNT = 32,
    parameter int IDX_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [7:0]       wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [7:0]       rd_data_o
);

    logic [7:0] mem_q [BYTE_COUNT];
    logic [7:0] rd_data_q;

    // NOTE: this array is cleared by reset, so it must stay a flop array;
    // a resettable memory cannot map onto block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BYTE_COUNT; i++) begin
                mem_q[i] <= 8'h00;
            end
            rd_data_q <= 8'h00;
        end else begin
            if (wr_en_i && (int'(wr_idx_i) < BYTE_COUNT)) begin
                mem_q[wr_idx_i] <= wr_data_i;
            end
            // Out-of-range indices (non power-of-two BYTE_COUNT) read as zero.
            rd_data_q <= (int'(rd_idx_i) < BYTE_COUNT) ? mem_q[rd_idx_i] : 8'h00;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/flash_read_engine.sv
// ---------------------------------------------------------------------------
// flash_read_engine
// Mode-0 SPI read engine: on start, sends READ (0x03) + 24-bit address, then
// clocks in BYTE_COUNT bytes into flash_byte_buffer and pulses done.
// One SPI bit = 2 clk cycles (phase 0: SCLK low, phase 1: SCLK high).
// Optional macro FLASH_STARTUP_WAIT_EN: hold ST_INIT_WAIT for STARTUP_WAIT
// cycles after reset (busy high, start ignored) before entering ST_IDLE.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   start, addr      read request and start byte address (sampled in IDLE)
//   busy, done       transaction in flight / one-cycle completion pulse
//   rdIndex, rdData  buffer read index and registered byte (1-cycle latency)
//   flashClk, flashCs, flashMosi, flashMiso   SPI pins (CS active low)
// All SPI pins and status outputs are registered, so SCLK is glitch-free.
// ---------------------------------------------------------------------------
module flash_read_engine
    import flash_pkg::*;
#(
    parameter int BYTE_COUNT   = 32,
    parameter int STARTUP_WAIT = 270000,
    localparam int IDX_W = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [FLASH_ADDR_W-1:0] addr,
    output logic                    busy,
    output logic                    done,
    input  logic [IDX_W-1:0]        rdIndex,
    output logic [7:0]              rdData,
    output logic                    flashClk,
    output logic                    flashCs,
    output logic                    flashMosi,
    input  logic                    flashMiso
);

    if (BYTE_COUNT < 1 || STARTUP_WAIT < 1) begin : g_cfg_check
        $error("flash_read_engine: BYTE_COUNT and STARTUP_WAIT must be >= 1");
    end

    state_e             state_q, state_d;
    logic               phase_q, phase_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;     // bit within frame or byte
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [6:0]         rx_q, rx_d;               // first 7 bits of a byte
    logic               cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               wr_en;
    logic [7:0]         wr_data;

`ifdef FLASH_STARTUP_WAIT_EN
    localparam int WAIT_W = $clog2(STARTUP_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    localparam state_e RST_STATE = ST_INIT_WAIT;
    localparam logic   RST_BUSY  = 1'b1;
`else
    localparam state_e RST_STATE = ST_IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_STATE;
            phase_q    <= 1'b0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            rx_q       <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= RST_BUSY;
            done_q     <= 1'b0;
`ifdef FLASH_STARTUP_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef FLASH_STARTUP_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        wr_en      = 1'b0;
        wr_data    = {rx_q, flashMiso};
`ifdef FLASH_STARTUP_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif

        case (state_q)
`ifdef FLASH_STARTUP_WAIT_EN
            ST_INIT_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (wait_cnt_q == WAIT_W'(STARTUP_WAIT - 1)) state_d = ST_IDLE;
            end
`endif
            ST_IDLE: begin
                if (start) begin
                    shift_d    = {CMD_READ, addr};
                    phase_d    = 1'b0;
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 5'(FRAME_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_READ: begin
                phase_d = ~phase_q;
                // Edge ending phase 1 is the SCLK falling edge: MISO was
                // launched on the previous falling edge and is stable here.
                if (phase_q) begin
                    rx_d      = {rx_q[5:0], flashMiso};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d  = '0;
                        wr_en      = 1'b1;
                        byte_idx_d = byte_idx_q + 1'b1;
                        if (byte_idx_q == IDX_W'(BYTE_COUNT - 1)) state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Pin/status values follow the next state so they register cleanly.
        cs_d   = ~drives_bus(state_d);
        sclk_d = drives_bus(state_d) && phase_d;
        mosi_d = (state_d == ST_SEND) && shift_d[FRAME_W-1];
        done_d = (state_d == ST_DONE);
`ifdef FLASH_STARTUP_WAIT_EN
        busy_d = drives_bus(state_d) || (state_d == ST_INIT_WAIT);
`else
        busy_d = drives_bus(state_d);
`endif
    end

    flash_byte_buffer #(
        .BYTE_COUNT (BYTE_COUNT),
        .IDX_W      (IDX_W)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_idx_i  (byte_idx_q),
        .wr_data_i (wr_data),
        .rd_idx_i  (rdIndex),
        .rd_data_o (rdData)
    );

    assign flashCs   = cs_q;
    assign flashClk  = sclk_q;
    assign flashMosi = mosi_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_flash_read_engine.sv
// Self-checking bench for flash_read_engine. A pin-level flash model decodes
// the command frame and serves bytes from a synthetic 4 MB memory image.
module tb_flash_read_engine;

    localparam int BC        = 32;
    localparam int TXN_CYC   = 2 * (32 + 8 * BC) + 1;   // done cycle, 577
    localparam int SCLK_RISE = 32 + 8 * BC;             // 288
`ifdef FLASH_STARTUP_WAIT_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start;
    logic [23:0] addr;
    logic        busy, done;
    logic [4:0]  rdIndex;
    logic [7:0]  rdData;
    logic        flashClk, flashCs, flashMosi;
    logic        flashMiso = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flash_read_engine #(.BYTE_COUNT(BC), .STARTUP_WAIT(50)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr),
        .busy(busy), .done(done), .rdIndex(rdIndex), .rdData(rdData),
        .flashClk(flashClk), .flashCs(flashCs), .flashMosi(flashMosi),
        .flashMiso(flashMiso)
    );

    // Memory image: 22-bit address space, so address wrap is implicit.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
    endfunction

    // ---------------- flash model (pin level, evaluated at negedge) -------
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [31:0] frame = '0;
    int          rise_cnt = 0;
    logic        mosi_bad = 1'b0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (prev_cs && !flashCs) begin
            rise_cnt = 0;
            frame    = '0;
            mosi_bad = 1'b0;
        end
        if (!flashCs && !prev_sclk && flashClk) begin
            if (rise_cnt < 32) frame = {frame[30:0], flashMosi};
            else if (flashMosi) mosi_bad = 1'b1;
            rise_cnt++;
        end
        if (!flashCs && prev_sclk && !flashClk && rise_cnt >= 32) begin
            int         bitpos;
            logic [7:0] b;
            bitpos    = rise_cnt - 32;
            b         = mem_byte(frame[23:0] + 24'(bitpos / 8));
            flashMiso = b[7 - (bitpos % 8)];
        end
        prev_cs   = flashCs;
        prev_sclk = flashClk;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 32'(n < 1000), 32'd1);
    endtask

    // restart_at: cycle to pulse start again (-1: on the done cycle, 0: never)
    // rst_at: cycle to assert rst (0: never)
    task automatic run_txn(input logic [23:0] a, input int restart_at, input int rst_at);
        int cyc;
        int done_before;
        wait_idle();
        @(negedge clk);
        start = 1'b1;
        addr  = a;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        done_before = done_cnt;
        check("cs_low_c1", flashCs, 0);
        check("busy_c1", busy, 1);
        while (!done && cyc < 1000) begin
            start = (cyc == restart_at);
            addr  = 24'($urandom);
            if (cyc == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                check("rst_cs", flashCs, 1);
                check("rst_sclk", flashClk, 0);
                check("rst_busy", busy, BUSY_RST);
                check("rst_done", done, 0);
                for (int i = 0; i < BC; i++) begin
                    rdIndex = 5'(i);
                    @(negedge clk);
                    check($sformatf("rst_buf[%0d]", i), rdData, 0);
                end
                repeat (600) @(negedge clk);
                check("rst_no_done", done_cnt, done_before);
                check("rst_cs_idle", flashCs, 1);
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start = (restart_at < 0);
        check("done_cycle", cyc, TXN_CYC);
        check("done_cs_high", flashCs, 1);
        check("done_sclk_low", flashClk, 0);
        check("done_busy_low", busy, 0);
        check("frame", frame, {8'h03, a});
        check("sclk_rises", rise_cnt, SCLK_RISE);
        check("mosi_low_in_read", mosi_bad, 0);
        @(negedge clk);
        start = 1'b0;
        check("done_pulse_width", done, 0);
        check("no_restart_busy", busy, 0);
        check("done_count", done_cnt, done_before + 1);
        for (int i = 0; i < BC; i++) begin
            rdIndex = 5'(i);
            @(negedge clk);
            check($sformatf("buf[%0d]@%06h", i, a), rdData, mem_byte(a + 24'(i)));
        end
        repeat (3) @(negedge clk);
        check("idle_after_txn", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; addr = '0; rdIndex = '0;
        repeat (3) @(negedge clk);
        check("reset_cs", flashCs, 1);
        check("reset_sclk", flashClk, 0);
        check("reset_mosi", flashMosi, 0);
        check("reset_busy", busy, BUSY_RST);
        check("reset_done", done, 0);
        check("reset_rddata", rdData, 0);
        rst = 1'b0;
`ifdef FLASH_STARTUP_WAIT_EN
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start = (k == 10);
            if (k == 12) begin
                check("init_busy_12", busy, 1);
                check("init_cs_12", flashCs, 1);
            end
            if (k == 49) check("init_busy_49", busy, 1);
            if (k == 50) check("init_busy_50", busy, 0);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
`endif
        run_txn(24'h000100, 0, 0);
        run_txn(24'h000000, 0, 0);
        run_txn(24'h3FFFF0, 100, 0);
        run_txn(24'($urandom), -1, 0);
        run_txn(24'($urandom), 0, 300);
        for (int t = 0; t < 4; t++) run_txn(24'($urandom), 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
